// File: rtl/cache_ctrl_assoc.sv
// cache_ctrl_assoc: 1- or 2-way set-associative, multi-word-line read cache.
// Write-through, no write-allocate, LRU replacement. Lines are filled word by
// word from the backing memory over a req/done handshake.
// Optional build macro CACHE_STATS_EN adds read hit/miss counters; without it
// hit_count and miss_count are tied to zero.
module cache_ctrl_assoc #(
  parameter int unsigned SETS       = 64,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 2,
  parameter int unsigned BASE_ADDR  = 1024,
  parameter int unsigned MEM_AW     = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_done,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int unsigned OW  = $clog2(LINE_WORDS);
  localparam int unsigned OWB = (OW > 0) ? OW : 1;
  localparam int unsigned IW  = $clog2(SETS);
  localparam int unsigned TW  = MEM_AW - OW - IW;

  localparam logic [OWB-1:0] LastWord = OWB'(LINE_WORDS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] FILL   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  logic [2:0]               state_q;
  logic [MEM_AW-1:0]        eff;
  logic [MEM_AW-1:0]        line_base;
  logic [OWB-1:0]           offset;
  logic [IW-1:0]            index;
  logic [TW-1:0]            tag;

  logic [TW-1:0]            tag_q  [WAYS][SETS];
  logic [31:0]              data_q [WAYS][SETS][LINE_WORDS];
  logic [WAYS-1:0][SETS-1:0] valid_q;
  logic [SETS-1:0]          lru_q;   // per set: index of the least recently used way

  logic [WAYS-1:0]          way_hit;
  logic                     hit;
  logic                     hit_way;
  logic                     victim;
  logic                     victim_q;
  logic [OWB-1:0]           word_q;
  logic [31:0]              hit_word;
  logic                     unused_addr;

  assign unused_addr = ^address[31:MEM_AW];

  // Address split: rebase, then offset / index / tag fields
  assign eff       = address[MEM_AW-1:0] - MEM_AW'(BASE_ADDR);
  assign line_base = eff & ~MEM_AW'(LINE_WORDS - 1);
  assign index     = eff[OW +: IW];
  assign tag       = eff[MEM_AW-1 -: TW];

  if (OW > 0) begin : g_offset
    assign offset = eff[OW-1:0];
  end else begin : g_no_offset
    assign offset = '0;
  end

  // Tag compare across ways and victim choice (invalid way first, else LRU)
  always_comb begin
    way_hit = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[w][index] && (tag_q[w][index] == tag);
    end
    hit     = |way_hit;
    hit_way = (WAYS > 1) && !way_hit[0];
    if (!valid_q[0][index]) begin
      victim = 1'b0;
    end else if ((WAYS > 1) && !valid_q[WAYS-1][index]) begin
      victim = 1'b1;
    end else begin
      victim = (WAYS > 1) ? lru_q[index] : 1'b0;
    end
    hit_word = data_q[hit_way][index][offset];
  end

  // CPU handshake; held low while reset is asserted even though IDLE is idle
  always_comb begin
    ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE:    ready = !rd_en && !wr_en;
        WRITE:   ready = mem_done;
        RESP:    ready = 1'b1;
        default: ready = 1'b0;
      endcase
    end
  end

  // Control FSM, valid/LRU state and registered memory-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      lru_q      <= '0;
      read_data  <= '0;
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      victim_q   <= 1'b0;
      word_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_en) begin
            state_q <= LOOKUP;
          end else if (wr_en) begin
            state_q    <= WRITE;
            mem_wr_req <= 1'b1;
            mem_addr   <= eff;
            mem_wdata  <= write_data;
            if (hit && (WAYS > 1)) lru_q[index] <= ~hit_way;
          end
        end
        LOOKUP: begin
          if (hit) begin
            read_data <= hit_word;
            if (WAYS > 1) lru_q[index] <= ~hit_way;
            state_q <= RESP;
          end else begin
            // Invalidate up front so an interrupted fill never looks valid
            valid_q[victim][index] <= 1'b0;
            victim_q   <= victim;
            word_q     <= '0;
            mem_rd_req <= 1'b1;
            mem_addr   <= line_base;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (!mem_rd_req) begin
            mem_rd_req <= 1'b1;
            mem_addr   <= line_base | MEM_AW'(word_q);
          end else if (mem_done) begin
            mem_rd_req <= 1'b0;
            if (word_q == offset) read_data <= mem_rdata;
            if (word_q == LastWord) begin
              valid_q[victim_q][index] <= 1'b1;
              if (WAYS > 1) lru_q[index] <= ~victim_q;
              state_q <= RESP;
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_done) begin
            mem_wr_req <= 1'b0;
            state_q    <= IDLE;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Data and tag arrays: write-hit update and line fill (never reset)
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && !rd_en && wr_en && hit) begin
      data_q[hit_way][index][offset] <= write_data;
    end
    if ((state_q == FILL) && mem_rd_req && mem_done) begin
      data_q[victim_q][index][word_q] <= mem_rdata;
      if (word_q == LastWord) tag_q[victim_q][index] <= tag;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // Read hit/miss statistics, counted on each lookup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hit_q  <= hit_q + 32'd1;
      else     miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Self-checking bench for cache_ctrl_assoc (default parameters).
// Backing memory: word a holds 0xA0 + a unless written; done 3 cycles after req.
module tb_cache_ctrl_assoc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  cache_ctrl_assoc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_rd  = 0;
  int unsigned n_wr  = 0;
  bit          both_req = 1'b0;

  logic [31:0] sb_q [$];
  logic [17:0] rd_addr_q [$];
  logic [17:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [31:0] wmem [int unsigned];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] eff_of(input logic [31:0] a);
    return a[17:0] - 18'd1024;
  endfunction

  function automatic logic [31:0] mem_val(input logic [17:0] a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    return 32'hA0 + {14'd0, a};
  endfunction

  // Backing-memory responder
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || mem_done) begin
        mem_done = 1'b0;
        cnt = 0;
      end else if (mem_rd_req || mem_wr_req) begin
        cnt++;
        if (cnt == 3) begin
          mem_done  = 1'b1;
          mem_rdata = mem_val(mem_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Memory-side monitor: log each new request
  initial begin
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_rd_req && mem_wr_req) both_req = 1'b1;
      if (mem_rd_req && !prev_rd) begin
        n_rd++;
        rd_addr_q.push_back(mem_addr);
      end
      if (mem_wr_req && !prev_wr) begin
        n_wr++;
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end
      prev_rd = mem_rd_req;
      prev_wr = mem_wr_req;
    end
  end

  task automatic wait_ready(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    repeat (200) begin
      @(negedge clk);
      cycles++;
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_read(input string name, input logic [31:0] addr, input int exp_reads,
                         input int exp_lat, input bit also_wr);
    int cycles;
    bit ok;
    int unsigned rd0, wr0;
    logic [17:0] e;
    logic [31:0] got_addr;
    e = eff_of(addr);
    sb_q.push_back(mem_val(e));
    rd0 = n_rd;
    wr0 = n_wr;
    @(negedge clk);
    address = addr;
    rd_en = 1'b1;
    wr_en = also_wr;
    wait_ready(cycles, ok);
    rd_en = 1'b0;
    wr_en = 1'b0;
    if (!ok) begin
      check_eq({name, "_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      check_eq({name, "_data"}, read_data, sb_q.pop_front());
      if (exp_lat >= 0) check_eq({name, "_lat"}, cycles, exp_lat);
    end
    check_eq({name, "_nreads"}, n_rd - rd0, exp_reads);
    check_eq({name, "_nwrites"}, n_wr - wr0, 0);
    for (int w = 0; w < exp_reads; w++) begin
      got_addr = (rd_addr_q.size() > 0) ? {14'd0, rd_addr_q.pop_front()} : 32'hFFFF_FFFF;
      check_eq({name, "_fill_addr"}, got_addr, {14'd0, (e & ~18'd1) + 18'(w)});
    end
  endtask

  task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data);
    int cycles;
    bit ok;
    int unsigned rd0, wr0;
    logic [17:0] e;
    e = eff_of(addr);
    rd0 = n_rd;
    wr0 = n_wr;
    @(negedge clk);
    address = addr;
    write_data = data;
    wr_en = 1'b1;
    wait_ready(cycles, ok);
    check_eq({name, "_ready_on_done"}, {31'd0, ok && mem_done}, 32'd1);
    wr_en = 1'b0;
    wmem[int'(e)] = data;
    check_eq({name, "_nwrites"}, n_wr - wr0, 1);
    check_eq({name, "_nreads"}, n_rd - rd0, 0);
    if (wr_addr_q.size() > 0) begin
      check_eq({name, "_addr"}, {14'd0, wr_addr_q.pop_front()}, {14'd0, e});
      check_eq({name, "_wdata"}, wr_data_q.pop_front(), data);
    end else begin
      check_eq({name, "_no_write_seen"}, 32'd0, 32'd1);
    end
  endtask

  function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef CACHE_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
    check_eq("rst_read_data", read_data, 32'd0);
    check_eq("rst_mem_addr", {14'd0, mem_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", {31'd0, ready}, 32'd1);

    // 1: cold miss fills line 0
    do_read("t1", 32'd1024, 2, -1, 1'b0);
    check_eq("t1_miss_count", miss_count, stat(32'd1));
    // 2: hit on the other word of the line
    do_read("t2", 32'd1025, 0, 2, 1'b0);
    check_eq("t2_hit_count", hit_count, stat(32'd1));
    // 3: write hit then read back from cache
    do_write("t3w", 32'd1025, 32'h55);
    do_read("t3r", 32'd1025, 0, 2, 1'b0);
    // 4: LRU eviction within set 0
    do_read("t4_128", 32'd1024 + 128, 2, -1, 1'b0);
    do_read("t4_0a", 32'd1024, 0, 2, 1'b0);
    do_read("t4_256", 32'd1024 + 256, 2, -1, 1'b0);
    do_read("t4_0b", 32'd1024, 0, 2, 1'b0);
    do_read("t4_128b", 32'd1024 + 128, 2, -1, 1'b0);
    check_eq("t4_hit_count", hit_count, stat(32'd4));
    check_eq("t4_miss_count", miss_count, stat(32'd4));

    // 5: reset during the second word of a fill
    @(negedge clk);
    address = 32'd1024 + 512;
    rd_en = 1'b1;
    ok = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (mem_done) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("t5_first_done", {31'd0, ok}, 32'd1);
    ok = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (mem_rd_req) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("t5_second_req", {31'd0, ok}, 32'd1);
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    check_eq("t5_req_dropped", {31'd0, mem_rd_req}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_addr_q.delete();
    do_read("t5_refill", 32'd1024 + 512, 2, -1, 1'b0);
    check_eq("t5_miss_count", miss_count, stat(32'd1));

    // 6: simultaneous rd/wr, address below the base wraps
    do_read("t6", 32'd0, 2, -1, 1'b1);
    check_eq("never_both_req", {31'd0, both_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
